// File: rtl/mux_scan_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the mux scan sequencer: the FSM state enum,
// the channel count, the select and counter widths and the default data width.
// ---------------------------------------------------------------------------
package mux_scan_pkg;

    localparam int NUM_CH         = 8;
    localparam int SEL_W          = 3;
    localparam int CNT_W          = 8;
    localparam int DEFAULT_DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer_if
// Valid/ready sample port of the scan sequencer.
//   sample_data  : captured mux output
//   sample_ch    : channel that sample_data was taken from
//   sample_valid : sample available
//   sample_ready : consumer accepts the sample
// The master modport is the sequencer side and the slave modport is the
// consumer side.
// ---------------------------------------------------------------------------
interface mux_scan_sequencer_if #(
    parameter int DATA_W = mux_scan_pkg::DEFAULT_DATA_W
);
    import mux_scan_pkg::*;

    logic [DATA_W-1:0] sample_data;
    logic [SEL_W-1:0]  sample_ch;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_data,
        output sample_ch,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_ch,
        input  sample_valid,
        output sample_ready
    );

endinterface

// File: rtl/mux_scan_sequencer_next_ch_finder.sv
// ---------------------------------------------------------------------------
// next_ch_finder
// Combinational search for the lowest enabled channel relative to a
// reference channel.
//   mask        : channel enable bits, bit n = channel n
//   cur_ch      : reference channel
//   include_cur : 1 = cur_ch itself may be returned, 0 = strictly above it
//   found       : an enabled channel exists in the searched range
//   next_ch     : lowest such channel (0 when found is 0)
// ---------------------------------------------------------------------------
module next_ch_finder
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur_ch,
    input  logic              include_cur,
    output logic              found,
    output logic [SEL_W-1:0]  next_ch
);

    // Walk from the top down so that the last hit written is the lowest one.
    always_comb begin
        found   = 1'b0;
        next_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && ((SEL_W'(i) > cur_ch) ||
                            (include_cur && (SEL_W'(i) == cur_ch)))) begin
                found   = 1'b1;
                next_ch = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// mux_scan_sequencer
// Steps the 8-to-1 mux select lines through every enabled channel in
// ascending order, waits DWELL settle cycles on each channel, captures the
// mux output and offers it with its channel number on a valid/ready port.
// Each start request runs one pass.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, stop         : begin a pass (only when idle) / abort a pass
//   ch_mask             : channel enables, latched at start
//   sel_a, sel_b, sel_c : mux select, {sel_a,sel_b,sel_c} = channel
//   z_in                : mux output
//   smp                 : sample port (data, channel, valid, ready)
//   busy, done          : pass in progress / one-cycle end-of-pass pulse
// DWELL must lie in 1..255. Every output comes straight from a register.
// ---------------------------------------------------------------------------
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [NUM_CH-1:0]    ch_mask,
    output logic                 sel_a,
    output logic                 sel_b,
    output logic                 sel_c,
    input  logic [DATA_W-1:0]    z_in,
    mux_scan_sequencer_if.master smp,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SEL_W-1:0]    ch_q, ch_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [NUM_CH-1:0]   find_mask;
    logic [SEL_W-1:0]    find_cur;
    logic                find_incl;
    logic                find_found;
    logic [SEL_W-1:0]    find_ch;

    // One finder serves both searches: in IDLE it looks at the live mask
    // from channel 0 inclusive, otherwise at the latched mask strictly above
    // the channel currently selected.
    assign find_incl = (state_q == IDLE);
    assign find_mask = find_incl ? ch_mask : mask_q;
    assign find_cur  = find_incl ? '0 : sel_q;

    next_ch_finder u_finder (
        .mask        (find_mask),
        .cur_ch      (find_cur),
        .include_cur (find_incl),
        .found       (find_found),
        .next_ch     (find_ch)
    );

    // stop overrides everything, including a start in IDLE and a handshake
    // in HOLD; it leaves sel and the last sample untouched.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (stop) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (find_found) begin
                            mask_d  = ch_mask;
                            sel_d   = find_ch;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            state_d = SETTLE;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end

                SETTLE: begin
                    if (cnt_q == LAST_CNT) begin
                        data_d  = z_in;
                        ch_d    = sel_q;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                HOLD: begin
                    if (smp.sample_ready) begin
                        valid_d = 1'b0;
                        if (find_found) begin
                            sel_d   = find_ch;
                            cnt_d   = '0;
                            state_d = SETTLE;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {sel_a, sel_b, sel_c} = sel_q;
    assign smp.sample_data       = data_q;
    assign smp.sample_ch         = ch_q;
    assign smp.sample_valid      = valid_q;
    assign busy                  = busy_q;
    assign done                  = done_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mux_scan_sequencer
// Drives two sequencers (DWELL=4 and DWELL=1) with the same control inputs.
// Each one reads its own view of a shared channel value table as z_in.
// A per-instance reference model, built from the list of channels still to
// visit and the settle time, predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_mux_scan_sequencer;
    import mux_scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       ready;
    logic [7:0] ch_mask;
    logic [3:0] z_table [8];

    int test_count = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h required %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int DW = (g == 0) ? 4 : 1;

        logic       sel_a, sel_b, sel_c, busy, done;
        logic [3:0] z_in;

        mux_scan_sequencer_if #(.DATA_W(4)) smp ();

        assign smp.sample_ready = ready;
        assign z_in = z_table[{sel_a, sel_b, sel_c}];

        mux_scan_sequencer #(.DWELL(DW), .DATA_W(4)) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start),
            .stop    (stop),
            .ch_mask (ch_mask),
            .sel_a   (sel_a),
            .sel_b   (sel_b),
            .sel_c   (sel_c),
            .z_in    (z_in),
            .smp     (smp),
            .busy    (busy),
            .done    (done)
        );

        bit       m_busy  = 1'b0;
        bit       m_valid = 1'b0;
        bit       m_done  = 1'b0;
        bit [2:0] m_sel   = '0;
        bit [2:0] m_ch    = '0;
        bit [3:0] m_data  = '0;
        int       settled = 0;
        int       rem_ch[$];

        // Check what the last edge produced, then predict the next edge from
        // the inputs that are now stable.
        always @(negedge clk) begin
            if (!rst_n) begin
                m_busy  = 1'b0;
                m_valid = 1'b0;
                m_done  = 1'b0;
                m_sel   = '0;
                m_ch    = '0;
                m_data  = '0;
                settled = 0;
                rem_ch.delete();
            end

            checkOutput($sformatf("dw%0d.busy", DW), 32'(busy), 32'(m_busy));
            checkOutput($sformatf("dw%0d.done", DW), 32'(done), 32'(m_done));
            checkOutput($sformatf("dw%0d.sel", DW), 32'({sel_a, sel_b, sel_c}), 32'(m_sel));
            checkOutput($sformatf("dw%0d.valid", DW), 32'(smp.sample_valid), 32'(m_valid));
            checkOutput($sformatf("dw%0d.data", DW), 32'(smp.sample_data), 32'(m_data));
            checkOutput($sformatf("dw%0d.ch", DW), 32'(smp.sample_ch), 32'(m_ch));

            if (rst_n) begin
                m_done = 1'b0;
                if (stop) begin
                    m_busy  = 1'b0;
                    m_valid = 1'b0;
                    rem_ch.delete();
                end else if (!m_busy) begin
                    if (start) begin
                        for (int c = 0; c < 8; c++) begin
                            if (ch_mask[c]) rem_ch.push_back(c);
                        end
                        if (rem_ch.size() == 0) begin
                            m_done = 1'b1;
                        end else begin
                            m_busy  = 1'b1;
                            m_sel   = 3'(rem_ch[0]);
                            settled = 0;
                        end
                    end
                end else if (m_valid) begin
                    if (ready) begin
                        m_valid = 1'b0;
                        void'(rem_ch.pop_front());
                        if (rem_ch.size() == 0) begin
                            m_busy = 1'b0;
                            m_done = 1'b1;
                        end else begin
                            m_sel   = 3'(rem_ch[0]);
                            settled = 0;
                        end
                    end
                end else begin
                    settled++;
                    if (settled == DW) begin
                        m_valid = 1'b1;
                        m_ch    = m_sel;
                        m_data  = z_table[m_sel];
                    end
                end
            end
        end
    end

    function automatic logic [2:0] sel0();
        return {gen_dut[0].sel_a, gen_dut[0].sel_b, gen_dut[0].sel_c};
    endfunction

    task automatic applyStimulus(input logic s, input logic p, input logic [7:0] m);
        start   = s;
        stop    = p;
        ch_mask = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int i = 0;
        while ((gen_dut[0].busy || gen_dut[1].busy) && (i < budget)) begin
            @(posedge clk);
            #1;
            i++;
        end
        checkOutput("idleTimeout", 32'(gen_dut[0].busy | gen_dut[1].busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic newTable();
        for (int i = 0; i < 8; i++) z_table[i] = 4'($urandom_range(0, 15));
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        ready   = 1'b1;
        ch_mask = '0;
        for (int i = 0; i < 8; i++) z_table[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // full scan, data = channel + 3
        for (int i = 0; i < 8; i++) z_table[i] = 4'((i + 3) % 16);
        applyStimulus(1'b1, 1'b0, 8'hFF);
        waitIdle(200);

        // sparse mask: channels 2, 5, 7
        newTable();
        applyStimulus(1'b1, 1'b0, 8'b1010_0100);
        waitIdle(200);

        // backpressure on channel 3
        newTable();
        applyStimulus(1'b1, 1'b0, 8'hFF);
        for (int i = 0; i < 100 && sel0() != 3'd3; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bpReachCh3", 32'(sel0()), 32'd3);
        ready = 1'b0;
        for (int i = 0; i < 100 && !gen_dut[0].smp.sample_valid; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        checkOutput("bpHoldSel", 32'(sel0()), 32'd3);
        checkOutput("bpHoldCh", 32'(gen_dut[0].smp.sample_ch), 32'd3);
        checkOutput("bpHoldValid", 32'(gen_dut[0].smp.sample_valid), 32'd1);
        ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bpAdvance", 32'(sel0()), 32'd4);
        waitIdle(200);

        // stop while holding a sample
        newTable();
        ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h3C);
        for (int i = 0; i < 100 && !gen_dut[0].smp.sample_valid; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b1, 8'h3C);
        checkOutput("stopBusy", 32'(gen_dut[0].busy), 32'd0);
        checkOutput("stopValid", 32'(gen_dut[0].smp.sample_valid), 32'd0);
        checkOutput("stopSel", 32'(sel0()), 32'd2);
        ready = 1'b1;
        waitIdle(50);

        // start and stop together, then an empty mask
        applyStimulus(1'b1, 1'b1, 8'hFF);
        checkOutput("startStopBusy", 32'(gen_dut[0].busy), 32'd0);
        waitIdle(50);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("emptyMaskDone", 32'(gen_dut[0].done), 32'd1);
        waitIdle(50);

        // single top channel
        newTable();
        applyStimulus(1'b1, 1'b0, 8'h80);
        checkOutput("singleSel", 32'(sel0()), 32'd7);
        waitIdle(100);

        // random passes with random backpressure, mid-pass noise and aborts
        for (int p = 0; p < 25; p++) begin
            newTable();
            applyStimulus(1'b1, 1'b0, 8'($urandom_range(0, 255)));
            for (int i = 0; i < 300 && (gen_dut[0].busy || gen_dut[1].busy); i++) begin
                ready   = ($urandom_range(0, 3) != 0);
                ch_mask = 8'($urandom_range(0, 255));
                start   = ($urandom_range(0, 7) == 0);
                stop    = ($urandom_range(0, 63) == 0);
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            stop  = 1'b0;
            ready = 1'b1;
            waitIdle(400);
        end

        // asynchronous reset in the middle of a settle period
        applyStimulus(1'b1, 1'b0, 8'hFF);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rstBusy", 32'(gen_dut[0].busy), 32'd0);
        checkOutput("rstDone", 32'(gen_dut[0].done), 32'd0);
        checkOutput("rstSel", 32'(sel0()), 32'd0);
        checkOutput("rstValid", 32'(gen_dut[0].smp.sample_valid), 32'd0);
        checkOutput("rstData", 32'(gen_dut[0].smp.sample_data), 32'd0);
        checkOutput("rstCh", 32'(gen_dut[0].smp.sample_ch), 32'd0);
        checkOutput("rstSelDw1", 32'({gen_dut[1].sel_a, gen_dut[1].sel_b, gen_dut[1].sel_c}), 32'd0);
        checkOutput("rstBusyDw1", 32'(gen_dut[1].busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        newTable();
        applyStimulus(1'b1, 1'b0, 8'h0F);
        waitIdle(100);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
